// File: rtl/countdown_timer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// countdown_timer_ctrl_pkg
//
// Shared definitions for the MM:SS countdown controller:
//   - cdt_state_e   : 3-bit controller state encoding
//   - DIGIT_MAX     : largest legal BCD digit from the keypad
//   - SEC_TENS_MAX  : largest legal tens-of-seconds digit
//   - *_LSB         : bit offsets of the four BCD fields in {min_t,min_u,sec_t,sec_u}
//   - LOADN_*       : per-digit active-low load patterns for the counter chain
//   - digit_at()    : extract one BCD field
//   - time_valid()  : range check of a complete MM:SS entry
// -----------------------------------------------------------------------------
package countdown_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4,
    ST_CLEAR = 3'd5
  } cdt_state_e;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Field offsets inside the 16-bit time word {min_t, min_u, sec_t, sec_u}.
  localparam int SEC_U_LSB = 0;
  localparam int SEC_T_LSB = 4;
  localparam int MIN_U_LSB = 8;
  localparam int MIN_T_LSB = 12;

  localparam logic [3:0] LOADN_ALL  = 4'h0;
  localparam logic [3:0] LOADN_NONE = 4'hF;

  function automatic logic [3:0] digit_at(input logic [15:0] v, input int lsb);
    return v[lsb +: 4];
  endfunction

  // A time word is loadable when every field is a decimal digit and the
  // tens-of-seconds field fits its mod-6 counter.
  function automatic logic time_valid(input logic [15:0] v);
    return (digit_at(v, SEC_U_LSB) <= DIGIT_MAX)    &&
           (digit_at(v, SEC_T_LSB) <= SEC_TENS_MAX) &&
           (digit_at(v, MIN_U_LSB) <= DIGIT_MAX)    &&
           (digit_at(v, MIN_T_LSB) <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//
// Free-running divide-by-TICK_DIV counter. Counts 0..TICK_DIV-1 while en is
// high and wraps; holds its value while en is low. sclr has priority over en
// and returns the count to zero. tick is high for the single enabled cycle
// in which the count sits at its terminal value (the wrap cycle).
//
// Ports
//   clk   in  1  clock, rising edge
//   clrn  in  1  asynchronous active-low reset
//   en    in  1  count enable
//   sclr  in  1  synchronous clear
//   tick  out 1  terminal-count strobe (combinational from count and en)
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic clrn,
  input  logic en,
  input  logic sclr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (sclr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_timer_ctrl
//
// Controller for an MM:SS BCD countdown chain (sec_u mod10, sec_t mod6,
// min_u mod10, min_t mod10). Collects keypad digits into an entry buffer,
// range-checks the entry on start, parallel-loads the chain, issues one
// decrement enable per TICK_DIV clocks, supports pause/resume and raises an
// alarm once the chain reads 00:00.
//
// Build option
//   CDT_ALARM_TIMEOUT_EN : when defined, DONE ends by itself after ALARM_SECS
//                          prescaler wraps; otherwise the alarm holds until
//                          start or clear.
//
// Ports
//   clk           in  1   clock, rising edge
//   clrn          in  1   asynchronous active-low reset
//   key_valid     in  1   key strobe, key_data valid
//   key_data      in  4   BCD digit from keypad
//   start         in  1   strobe: start / resume
//   stop          in  1   strobe: pause
//   clear         in  1   strobe: abort and zero everything
//   cnt_zero_all  in  1   all four chain digits are zero
//   cnt_data      out 16  chain load value {min_t,min_u,sec_t,sec_u}
//   cnt_loadn     out 4   per-digit active-low load, [0]=sec_u
//   cnt_en        out 1   decrement enable into sec_u
//   entry         out 16  entry buffer for the display
//   running       out 1   high in RUN
//   paused        out 1   high in PAUSE
//   alarm         out 1   high in DONE
//   err           out 1   one-cycle pulse on a rejected start
//   dbg_state     out 3   current controller state (cdt_state_e encoding)
//
// Strobe semantics: key_valid, start, stop and clear are single-cycle
// strobes with no back-pressure; each is acted on in the cycle it is high or
// dropped. When several arrive together, clear > stop > start > key_valid.
//
// All outputs are registered from the next state, so they line up with the
// state register and cnt_en cannot glitch.
// -----------------------------------------------------------------------------
module countdown_timer_ctrl
  import countdown_timer_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_data,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        cnt_zero_all,
  output logic [15:0] cnt_data,
  output logic [3:0]  cnt_loadn,
  output logic        cnt_en,
  output logic [15:0] entry,
  output logic        running,
  output logic        paused,
  output logic        alarm,
  output logic        err,
  output logic [2:0]  dbg_state
);

`ifdef CDT_ALARM_TIMEOUT_EN
  localparam bit ALARM_TIMEOUT_EN = 1'b1;
`else
  localparam bit ALARM_TIMEOUT_EN = 1'b0;
`endif

  localparam int unsigned ALARM_W = $clog2(ALARM_SECS + 1);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  cdt_state_e   state_q, state_d;

  logic [15:0]  entry_q, entry_d;
  logic [15:0]  cnt_data_q, cnt_data_d;
  logic [3:0]   loadn_q, loadn_d;
  logic         cnt_en_q, cnt_en_d;
  logic         running_q, running_d;
  logic         paused_q, paused_d;
  logic         alarm_q, alarm_d;
  logic         err_q, err_d;

  logic [ALARM_W-1:0] alarm_cnt_q, alarm_cnt_d;

  logic         tick;
  logic         pre_en;
  logic         pre_sclr;
  logic         key_ok;
  logic         start_ok;
  logic         start_bad;
  logic         timeout_hit;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  assign key_ok    = key_valid && (key_data <= DIGIT_MAX);
  // An all-zero entry is neither loadable nor an error: start is just ignored.
  assign start_ok  = (entry_q != 16'h0000) &&  time_valid(entry_q);
  assign start_bad = (entry_q != 16'h0000) && !time_valid(entry_q);

  // ---------------------------------------------------------------------------
  // Prescaler control
  // ---------------------------------------------------------------------------
  // In RUN the prescaler only advances when the controller stays in RUN, so a
  // stop freezes it at the value it had when stop arrived and resume picks the
  // second up from exactly there. A stop coinciding with the terminal count
  // therefore also swallows that tick.
  assign pre_en = ((state_q == ST_RUN) && !stop && !clear) ||
                  (ALARM_TIMEOUT_EN && (state_q == ST_DONE));

  // Cleared while loading/clearing, and on the way into DONE so the alarm
  // timeout measures whole seconds from the moment the alarm rises.
  assign pre_sclr = (state_q == ST_LOAD) || (state_q == ST_CLEAR) ||
                    ((state_q == ST_RUN) && (state_d == ST_DONE));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .clrn (clrn),
    .en   (pre_en),
    .sclr (pre_sclr),
    .tick (tick)
  );

  // ---------------------------------------------------------------------------
  // Alarm timeout: counts prescaler wraps while in DONE
  // ---------------------------------------------------------------------------
  always_comb begin
    alarm_cnt_d = alarm_cnt_q;
    if (state_q != ST_DONE) begin
      alarm_cnt_d = '0;
    end else if (tick) begin
      alarm_cnt_d = alarm_cnt_q + ALARM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      alarm_cnt_q <= '0;
    end else begin
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign timeout_hit = ALARM_TIMEOUT_EN && (state_q == ST_DONE) && tick &&
                       (alarm_cnt_q == ALARM_W'(ALARM_SECS - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stop && start && start_ok) begin
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          // Zero is only trusted while no decrement is in flight; cnt_en is
          // never raised at zero, so the chain cannot wrap to 59:59.
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (cnt_zero_all && !cnt_en_q) begin
            state_d = ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (!stop && start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if ((!stop && start) || timeout_hit) begin
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    entry_d    = entry_q;
    cnt_data_d = cnt_data_q;
    loadn_d    = LOADN_NONE;
    err_d      = 1'b0;
    running_d  = (state_d == ST_RUN);
    paused_d   = (state_d == ST_PAUSE);
    alarm_d    = (state_d == ST_DONE);

    case (state_d)
      ST_LOAD: begin
        cnt_data_d = entry_q;
        loadn_d    = LOADN_ALL;
      end
      ST_CLEAR: begin
        cnt_data_d = '0;
        loadn_d    = LOADN_ALL;
        entry_d    = '0;
      end
      default: begin
      end
    endcase

    // Keypad and rejected-start handling only while idling; a pending stop
    // outranks start and keys even though stop has no effect in IDLE.
    if ((state_q == ST_IDLE) && (state_d == ST_IDLE) && !stop) begin
      if (start) begin
        err_d = start_bad;
      end else if (key_ok) begin
        entry_d = {entry_q[11:0], key_data};
      end
    end

    // One decrement per prescaler wrap, only while staying in RUN and never
    // with the chain at zero. LOAD and CLEAR are excluded by construction.
    cnt_en_d = (state_q == ST_RUN) && (state_d == ST_RUN) && tick && !cnt_zero_all;
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      entry_q    <= '0;
      cnt_data_q <= '0;
      loadn_q    <= LOADN_NONE;
      cnt_en_q   <= 1'b0;
      running_q  <= 1'b0;
      paused_q   <= 1'b0;
      alarm_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      cnt_data_q <= cnt_data_d;
      loadn_q    <= loadn_d;
      cnt_en_q   <= cnt_en_d;
      running_q  <= running_d;
      paused_q   <= paused_d;
      alarm_q    <= alarm_d;
      err_q      <= err_d;
    end
  end

  assign entry     = entry_q;
  assign cnt_data  = cnt_data_q;
  assign cnt_loadn = loadn_q;
  assign cnt_en    = cnt_en_q;
  assign running   = running_q;
  assign paused    = paused_q;
  assign alarm     = alarm_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer_ctrl
//
// Drives countdown_timer_ctrl (TICK_DIV=4, ALARM_SECS=3) against a behavioural
// MM:SS counter chain. Every chain decrement is compared against a queue of
// expected chain values pushed when the run is started or resumed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_countdown_timer_ctrl;
  import countdown_timer_ctrl_pkg::*;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned ALARM_SECS = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  always #5 clk = ~clk;

  logic        key_valid = 1'b0;
  logic [3:0]  key_data  = 4'h0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        clear = 1'b0;
  logic        cnt_zero_all;
  logic [15:0] cnt_data;
  logic [3:0]  cnt_loadn;
  logic        cnt_en;
  logic [15:0] entry;
  logic        running;
  logic        paused;
  logic        alarm;
  logic        err;
  logic [2:0]  dbg_state;

  countdown_timer_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .ALARM_SECS (ALARM_SECS)
  ) dut (
    .clk          (clk),
    .clrn         (clrn),
    .key_valid    (key_valid),
    .key_data     (key_data),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .cnt_zero_all (cnt_zero_all),
    .cnt_data     (cnt_data),
    .cnt_loadn    (cnt_loadn),
    .cnt_en       (cnt_en),
    .entry        (entry),
    .running      (running),
    .paused       (paused),
    .alarm        (alarm),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Counter chain model: sec_u mod10 -> sec_t mod6 -> min_u mod10 -> min_t mod10
  // Loads are honoured only while en is low.
  // ---------------------------------------------------------------------------
  logic [3:0]  su, st, mu, mt;
  logic [15:0] chain;
  assign chain        = {mt, mu, st, su};
  assign cnt_zero_all = (chain == 16'h0000);

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      {mt, mu, st, su} <= 16'h0000;
    end else if (cnt_en) begin
      if (su != 4'd0) su <= su - 4'd1;
      else begin
        su <= 4'd9;
        if (st != 4'd0) st <= st - 4'd1;
        else begin
          st <= 4'd5;
          if (mu != 4'd0) mu <= mu - 4'd1;
          else begin
            mu <= 4'd9;
            mt <= (mt != 4'd0) ? mt - 4'd1 : 4'd9;
          end
        end
      end
    end else begin
      if (!cnt_loadn[0]) su <= cnt_data[3:0];
      if (!cnt_loadn[1]) st <= cnt_data[7:4];
      if (!cnt_loadn[2]) mu <= cnt_data[11:8];
      if (!cnt_loadn[3]) mt <= cnt_data[15:12];
    end
  end

  // ---------------------------------------------------------------------------
  // Checker and scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // A decrement is issued in the cycle cnt_en is high and visible on the
  // chain one cycle later; that is when the oldest expectation is popped.
  logic en_seen   = 1'b0;
  int   en_pulses = 0;
  always @(negedge clk) begin
    if (!clrn) begin
      en_seen <= 1'b0;
    end else begin
      if (cnt_en) en_pulses <= en_pulses + 1;
      if (en_seen) begin
        if (exp_q.size() == 0) check_eq("sb_unexpected_dec", 32'(exp_q.size()), 32'd1);
        else                   check_eq("sb_chain_after_dec", 32'(chain), 32'(exp_q.pop_front()));
      end
      en_seen <= cnt_en;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 ns after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_data  = d;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic enter_time(input logic [15:0] t);
    for (int i = 3; i >= 0; i--) press(t[i*4 +: 4]);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int p0;
  int waited;

  initial begin
    // Reset values while clrn is held low
    step(2);
    check_eq("rst_state",   32'(dbg_state), 32'(ST_IDLE));
    check_eq("rst_loadn",   32'(cnt_loadn), 32'h0000_000F);
    check_eq("rst_cnt_en",  32'(cnt_en),    32'd0);
    check_eq("rst_entry",   32'(entry),     32'd0);
    check_eq("rst_data",    32'(cnt_data),  32'd0);
    check_eq("rst_status",  32'({running, paused, alarm, err}), 32'd0);
    clrn = 1'b1;
    step(1);

    // --- 01:30 entry, load, first decrement, pause/resume mid-second, clear
    enter_time(16'h0130);
    check_eq("t1_entry", 32'(entry), 32'h0130);
    press(4'hC);
    check_eq("t1_entry_bad_key", 32'(entry), 32'h0130);
    exp_q.push_back(16'h0129);
    pulse_start();
    check_eq("t1_load_state", 32'(dbg_state), 32'(ST_LOAD));
    check_eq("t1_load_loadn", 32'(cnt_loadn), 32'd0);
    check_eq("t1_load_data",  32'(cnt_data),  32'h0130);
    check_eq("t1_load_en",    32'(cnt_en),    32'd0);
    step(1);
    check_eq("t1_run_running", 32'(running),   32'd1);
    check_eq("t1_run_loadn",   32'(cnt_loadn), 32'h0000_000F);
    check_eq("t1_run_chain",   32'(chain),     32'h0130);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_no_early_en", 32'(cnt_en), 32'd0);
      step(1);
    end
    check_eq("t1_first_en", 32'(cnt_en), 32'd1);
    step(2);                       // prescaler now at 2
    pulse_stop();
    check_eq("t1_paused",       32'(paused),  32'd1);
    check_eq("t1_pause_running", 32'(running), 32'd0);
    p0 = en_pulses;
    step(20);
    check_eq("t1_pause_no_en", 32'(en_pulses - p0), 32'd0);
    exp_q.push_back(16'h0128);
    pulse_start();
    check_eq("t1_resume_running", 32'(running), 32'd1);
    check_eq("t1_resume_en0",     32'(cnt_en),  32'd0);
    step(1);
    check_eq("t1_resume_en1",     32'(cnt_en),  32'd0);
    step(1);
    check_eq("t1_resume_en2",     32'(cnt_en),  32'd1);
    pulse_clear();
    check_eq("t1_clear_state", 32'(dbg_state), 32'(ST_CLEAR));
    check_eq("t1_clear_loadn", 32'(cnt_loadn), 32'd0);
    check_eq("t1_clear_en",    32'(cnt_en),    32'd0);
    step(1);
    check_eq("t1_idle_chain",  32'(chain),     32'd0);
    check_eq("t1_idle_entry",  32'(entry),     32'd0);

    // --- 00:02 runs to DONE: exactly two decrements, no wrap
    enter_time(16'h0002);
    p0 = en_pulses;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    pulse_start();
    waited = 0;
    while (!alarm && waited < 40) begin
      step(1);
      waited++;
    end
    check_eq("t3_done_latency", 32'(waited), 32'd11);
    check_eq("t3_pulses", 32'(en_pulses - p0), 32'd2);
    check_eq("t3_chain_zero", 32'(chain), 32'd0);
    check_eq("t3_done_state", 32'(dbg_state), 32'(ST_DONE));
`ifdef CDT_ALARM_TIMEOUT_EN
    step(11);
    check_eq("t3_alarm_hold", 32'(alarm), 32'd1);
    step(1);
    check_eq("t3_alarm_timeout", 32'(alarm), 32'd0);
    check_eq("t3_timeout_state", 32'(dbg_state), 32'(ST_CLEAR));
    step(1);
`else
    step(12);
    check_eq("t3_alarm_hold", 32'(alarm), 32'd1);
    check_eq("t3_no_third", 32'(en_pulses - p0), 32'd2);
    pulse_start();
    check_eq("t3_start_clears", 32'(dbg_state), 32'(ST_CLEAR));
    check_eq("t3_alarm_off",    32'(alarm),     32'd0);
    step(1);
`endif
    check_eq("t3_back_idle", 32'(dbg_state), 32'(ST_IDLE));

    // --- 00:70 rejected, zero entry ignored
    enter_time(16'h0070);
    check_eq("t2_entry", 32'(entry), 32'h0070);
    pulse_start();
    check_eq("t2_err",   32'(err),       32'd1);
    check_eq("t2_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("t2_loadn", 32'(cnt_loadn), 32'h0000_000F);
    step(1);
    check_eq("t2_err_pulse", 32'(err), 32'd0);
    pulse_clear();
    step(1);
    pulse_start();
    check_eq("t2_zero_start_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("t2_zero_start_err",   32'(err),       32'd0);

    // --- Clear mid-RUN at 05:17
    enter_time(16'h0517);
    pulse_start();
    step(1);
    check_eq("t4_chain", 32'(chain), 32'h0517);
    step(2);
    pulse_clear();
    check_eq("t4_clear_state", 32'(dbg_state), 32'(ST_CLEAR));
    check_eq("t4_clear_loadn", 32'(cnt_loadn), 32'd0);
    check_eq("t4_clear_data",  32'(cnt_data),  32'd0);
    check_eq("t4_clear_entry", 32'(entry),     32'd0);
    step(1);
    check_eq("t4_idle_state",   32'(dbg_state), 32'(ST_IDLE));
    check_eq("t4_idle_running", 32'(running),   32'd0);
    check_eq("t4_idle_chain",   32'(chain),     32'd0);

    // --- Stop on the terminal count suppresses that tick; then async reset
    enter_time(16'h0030);
    pulse_start();
    step(1);
    step(3);                       // prescaler at terminal count
    p0 = en_pulses;
    pulse_stop();
    check_eq("t5_paused", 32'(paused), 32'd1);
    check_eq("t5_no_en",  32'(cnt_en), 32'd0);
    step(3);
    check_eq("t5_pause_quiet", 32'(en_pulses - p0), 32'd0);
    exp_q.push_back(16'h0029);
    pulse_start();
    check_eq("t5_resume_en0", 32'(cnt_en), 32'd0);
    step(1);
    check_eq("t5_resume_en1", 32'(cnt_en), 32'd1);
    step(2);
    check_eq("t5_still_run", 32'(running), 32'd1);
    clrn = 1'b0;
    #1;
    check_eq("t6_rst_state",  32'(dbg_state), 32'(ST_IDLE));
    check_eq("t6_rst_loadn",  32'(cnt_loadn), 32'h0000_000F);
    check_eq("t6_rst_data",   32'(cnt_data),  32'd0);
    check_eq("t6_rst_entry",  32'(entry),     32'd0);
    check_eq("t6_rst_status", 32'({cnt_en, running, paused, alarm, err}), 32'd0);
    step(2);
    clrn = 1'b1;
    step(2);
    check_eq("t6_post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
